transmit: RTL and testbench

- UART serial transmitter: accepts one byte per valid/ready handshake and shifts it out on txd as 8N1 at BAUDRATE, derived from the FREQUENCY system clock.
- Sits between a byte-stream producer (host/debug logic) and the board's serial TX pin.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/baud_tick.sv | 40 ++++
 rtl/transmit.sv | 153 +++++++++++++++
 tb/tb_transmit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter:
//   state_t      - transmit FSM states (PARITY is only reachable when the
//                  TRANSMIT_PARITY_EN macro is defined)
//   DATA_BITS    - payload bits per frame
//   calc_cycles  - clocks per serial bit, floor(FREQUENCY/BAUDRATE)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic int calc_cycles(input int baudrate, input int frequency);
    return frequency / baudrate;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// -----------------------------------------------------------------------------
// baud_tick
// Bit-period counter. Counts 0..CYCLES-1 and asserts o_tick during the last
// clock of each bit period. Held at zero while i_clear is high, so the first
// bit of a frame always gets a full CYCLES clocks.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-low reset
//   i_clear  in   hold the counter at zero (FSM idle)
//   o_tick   out  high for one clock when the counter is at CYCLES-1
// -----------------------------------------------------------------------------
module baud_tick #(
  parameter int CYCLES = 1250
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = $clog2(CYCLES);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(CYCLES - 1));
  assign o_tick = w_last;

  // Wrap to zero on the last count so the counter restarts on every bit change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/transmit.sv
// -----------------------------------------------------------------------------
// transmit
// UART transmitter, 8N1 (8E1 when TRANSMIT_PARITY_EN is defined). Accepts one
// byte per stb/rdy handshake and shifts it out LSB first on txd.
// Optional feature macro: TRANSMIT_PARITY_EN adds an even-parity bit between
// the last data bit and the stop bit.
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-low reset
//   stb  in   byte-valid strobe from producer
//   dat  in   byte to send, sampled only on the accepting edge
//   rdy  out  ready; byte accepted on an edge with stb && rdy
//   txd  out  registered serial line, idles high
// -----------------------------------------------------------------------------
module transmit
  import uart_pkg::*;
#(
  parameter int BAUDRATE  = 9600,
  parameter int FREQUENCY = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stb,
  input  logic [7:0] dat,
  output logic       rdy,
  output logic       txd
);

  localparam int CYCLES = calc_cycles(BAUDRATE, FREQUENCY);

  generate
    if (CYCLES < 2) begin : g_bad_cycles
      $error("transmit: FREQUENCY/BAUDRATE must be at least 2");
    end
  endgenerate

  state_t                 r_state, w_state_next;
  logic [DATA_BITS-1:0]   r_shift, w_shift_next;
  logic [2:0]             r_idx,   w_idx_next;
  logic                   r_txd,   w_txd_next;
  logic                   r_rdy,   w_rdy_next;
  logic                   w_tick;
`ifdef TRANSMIT_PARITY_EN
  logic                   r_par,   w_par_next;
`endif

  // Counter is parked in IDLE, so it starts from zero on the accepting edge.
  baud_tick #(
    .CYCLES (CYCLES)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == IDLE),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_txd   <= 1'b1;
      r_rdy   <= 1'b0;
`ifdef TRANSMIT_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_idx   <= w_idx_next;
      r_txd   <= w_txd_next;
      r_rdy   <= w_rdy_next;
`ifdef TRANSMIT_PARITY_EN
      r_par   <= w_par_next;
`endif
    end
  end

  // r_shift[0] always holds the bit currently on the line during DATA, so the
  // next bit to drive is r_shift[1].
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_idx_next   = r_idx;
    w_txd_next   = r_txd;
    w_rdy_next   = r_rdy;
`ifdef TRANSMIT_PARITY_EN
    w_par_next   = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_txd_next = 1'b1;
        w_rdy_next = 1'b1;
        if (stb && r_rdy) begin
          w_state_next = START;
          w_shift_next = dat;
          w_idx_next   = '0;
          w_txd_next   = 1'b0;
          w_rdy_next   = 1'b0;
`ifdef TRANSMIT_PARITY_EN
          w_par_next   = ^dat;
`endif
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next = DATA;
          w_txd_next   = r_shift[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_idx == 3'(DATA_BITS - 1)) begin
`ifdef TRANSMIT_PARITY_EN
            w_state_next = PARITY;
            w_txd_next   = r_par;
`else
            w_state_next = STOP;
            w_txd_next   = 1'b1;
`endif
          end else begin
            w_idx_next   = r_idx + 3'd1;
            w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
            w_txd_next   = r_shift[1];
          end
        end
      end
`ifdef TRANSMIT_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          w_state_next = STOP;
          w_txd_next   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_tick) begin
          w_state_next = IDLE;
          w_txd_next   = 1'b1;
          w_rdy_next   = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_txd_next   = 1'b1;
      end
    endcase
  end

  assign rdy = r_rdy;
  assign txd = r_txd;

endmodule

// File: tb/tb_transmit.sv
// -----------------------------------------------------------------------------
// tb_transmit
// Directed bench for the UART transmitter with a short bit period
// (FREQUENCY/BAUDRATE = 10 clocks). Decodes txd at mid-bit and checks framing,
// handshake timing, back-to-back spacing, ignored mid-frame strobes and reset
// abort. Honours TRANSMIT_PARITY_EN for the frame length and parity bit.
// -----------------------------------------------------------------------------
module tb_transmit;

  localparam int BAUD = 1;
  localparam int FREQ = 10;
  localparam int C    = 10;
`ifdef TRANSMIT_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stb = 1'b0;
  logic [7:0] dat = 8'h00;
  logic       rdy;
  logic       txd;

  int checks   = 0;
  int failures = 0;

  transmit #(
    .BAUDRATE  (BAUD),
    .FREQUENCY (FREQ)
  ) dut (
    .clk (clk),
    .rst (rst),
    .stb (stb),
    .dat (dat),
    .rdy (rdy),
    .txd (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
    $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Producer has stb/dat set; wait (bounded) until rdy is seen, then step over
  // the accepting edge.
  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy_wait"}, {31'd0, rdy}, 32'd1);
    @(posedge clk);
  endtask

  // Called just after the accepting edge. Samples each bit at mid-bit and
  // checks rdy stays low for exactly FB*C clocks.
  task automatic frame(input string tag, input logic [7:0] exp, input bit hold,
                       input logic [7:0] nxt, input bit poke);
    logic [FB-1:0] bits;
    bit            rdy_seen;
    bits     = '0;
    rdy_seen = 1'b0;
    @(negedge clk);
    check({tag, "_rdy_drop"}, {31'd0, rdy}, 32'd0);
    check({tag, "_start_edge"}, {31'd0, txd}, 32'd0);
    if (hold) dat = nxt;
    else      stb = 1'b0;
    for (int j = 1; j <= FB * C; j++) begin
      @(negedge clk);
      if (poke && j == 3 * C) begin
        stb = 1'b1;
        dat = ~exp;
      end
      if (poke && j == 3 * C + 3) begin
        stb = 1'b0;
        dat = 8'h00;
      end
      if (j % C == C / 2) bits[j / C] = txd;
      if (j < FB * C && rdy) rdy_seen = 1'b1;
    end
    check({tag, "_rdy_low"}, {31'd0, rdy_seen}, 32'd0);
    check({tag, "_rdy_back"}, {31'd0, rdy}, 32'd1);
    check({tag, "_idle_txd"}, {31'd0, txd}, 32'd1);
    check({tag, "_start"}, {31'd0, bits[0]}, 32'd0);
    check({tag, "_data"}, {24'd0, bits[8:1]}, {24'd0, exp});
`ifdef TRANSMIT_PARITY_EN
    check({tag, "_parity"}, {31'd0, bits[9]}, {31'd0, ^exp});
`endif
    check({tag, "_stop"}, {31'd0, bits[FB-1]}, 32'd1);
    $display("frame %s byte=0x%02h bits=%b", tag, exp, bits);
  endtask

  initial begin
    bit extra;

    // Reset held for three edges
    rst = 1'b0;
    stb = 1'b0;
    dat = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_rdy", {31'd0, rdy}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rel_rdy", {31'd0, rdy}, 32'd1);
    check("rel_txd", {31'd0, txd}, 32'd1);

    // 0x55 then 0xAA
    stb = 1'b1; dat = 8'h55;
    wait_accept("b55");
    frame("b55", 8'h55, 1'b0, 8'h00, 1'b0);

    @(negedge clk);
    stb = 1'b1; dat = 8'hAA;
    wait_accept("bAA");
    frame("bAA", 8'hAA, 1'b0, 8'h00, 1'b0);

    // Back-to-back: stb stays high, next byte follows after one idle cycle
    @(negedge clk);
    stb = 1'b1; dat = 8'h00;
    wait_accept("b2b0");
    frame("b2b0", 8'h00, 1'b1, 8'hFF, 1'b0);
    @(posedge clk);
    frame("b2b1", 8'hFF, 1'b0, 8'h00, 1'b0);

    // Mid-frame strobe/data changes are ignored, no extra frame follows
    @(negedge clk);
    stb = 1'b1; dat = 8'h3C;
    wait_accept("ign");
    frame("ign", 8'h3C, 1'b0, 8'h00, 1'b1);
    extra = 1'b0;
    for (int i = 0; i < 2 * C; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || rdy !== 1'b1) extra = 1'b1;
    end
    check("ign_no_extra", {31'd0, extra}, 32'd0);

    // Reset during data bit 3 of 0xC3 (bit 3 = 0, so txd is low when hit)
    @(negedge clk);
    stb = 1'b1; dat = 8'hC3;
    wait_accept("rmf");
    @(negedge clk);
    stb = 1'b0;
    repeat (4 * C + C / 2) @(negedge clk);
    check("rmf_bit3", {31'd0, txd}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rmf_abort_txd", {31'd0, txd}, 32'd1);
    check("rmf_abort_rdy", {31'd0, rdy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rmf_rel_rdy", {31'd0, rdy}, 32'd1);
    check("rmf_rel_txd", {31'd0, txd}, 32'd1);

    stb = 1'b1; dat = 8'h5A;
    wait_accept("b5A");
    frame("b5A", 8'h5A, 1'b0, 8'h00, 1'b0);

`ifdef TRANSMIT_PARITY_EN
    @(negedge clk);
    stb = 1'b1; dat = 8'h07;
    wait_accept("b07");
    frame("b07", 8'h07, 1'b0, 8'h00, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
